// File: rtl/reset_ctrl_pkg.sv
// Shared clock-unit types: reset sequencer states and default cycle counts.
package types;

  localparam bit          USB_FULL_SPEED          = 1'b1;

  localparam int unsigned RST_CNT_W               = 17;
  localparam int unsigned DEF_PLL_RST_CYCLES      = 8;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_USB_DELAY_CYCLES    = 16;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABILIZE,
    CPU_RUN,
    RUN
  } rst_state_t;

endpackage

// File: rtl/reset_ctrl_sync2.sv
// Generic two-flop bit synchronizer, asynchronous active-high reset to 0.
module sync2 (
  input  logic clk_i,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] ff_q;
  logic [1:0] ff_d;

  always_comb ff_d = {ff_q[0], d};

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) ff_q <= '0;
    else     ff_q <= ff_d;
  end

  assign q = ff_q[1];

endmodule

// File: rtl/reset_ctrl.sv
// PLL / CPU / USB reset sequencer on the reference clock.
module reset_ctrl
  import types::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned USB_DELAY_CYCLES    = DEF_USB_DELAY_CYCLES
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       pll_areset,
  output logic       reset_cpu,
  output logic       reset_usb,
  output logic       ready,
  output logic [7:0] lock_lost_cnt
);

  logic locked_s;

  sync2 u_lock_sync (
    .clk_i (clk_i),
    .rst   (reset),
    .d     (pll_locked),
    .q     (locked_s)
  );

  rst_state_t             state_q, state_d;
  logic [RST_CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]             lost_q, lost_d;
  logic                   pll_areset_q, pll_areset_d;
  logic                   reset_cpu_q, reset_cpu_d;
  logic                   reset_usb_q, reset_usb_d;
  logic                   ready_q, ready_d;

  logic pll_rst_done, lock_timeout, lock_stable, usb_delay_done;

  assign pll_rst_done   = (cnt_q == RST_CNT_W'(PLL_RST_CYCLES - 1));
  assign lock_timeout   = (cnt_q == RST_CNT_W'(LOCK_TIMEOUT_CYCLES - 1));
  assign lock_stable    = (cnt_q == RST_CNT_W'(LOCK_STABLE_CYCLES - 1));
  assign usb_delay_done = (cnt_q == RST_CNT_W'(USB_DELAY_CYCLES - 1));

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      lost_q       <= '0;
      pll_areset_q <= 1'b1;
      reset_cpu_q  <= 1'b1;
      reset_usb_q  <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lost_q       <= lost_d;
      pll_areset_q <= pll_areset_d;
      reset_cpu_q  <= reset_cpu_d;
      reset_usb_q  <= reset_usb_d;
      ready_q      <= ready_d;
    end
  end

  // Lock loss takes priority over soft reset in the running states.
  always_comb begin
    state_d = state_q;
    lost_d  = lost_q;
    unique case (state_q)
      PLL_RST:   if (pll_rst_done) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (locked_s)          state_d = STABILIZE;
        else if (lock_timeout) state_d = PLL_RST;
      end
      STABILIZE: begin
        if (!locked_s)        state_d = WAIT_LOCK;
        else if (lock_stable) state_d = CPU_RUN;
      end
      CPU_RUN, RUN: begin
        if (!locked_s) begin
          state_d = PLL_RST;
          if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
        end else if (soft_reset) begin
          state_d = STABILIZE;
        end else if (state_q == CPU_RUN && usb_delay_done) begin
          state_d = RUN;
        end
      end
      default:   state_d = PLL_RST;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + RST_CNT_W'(1);
  end

  // Outputs are decoded from the next state so they move with the state.
  always_comb begin
    pll_areset_d = 1'b0;
    reset_cpu_d  = 1'b1;
    reset_usb_d  = 1'b1;
    ready_d      = 1'b0;
    unique case (state_d)
      PLL_RST:   pll_areset_d = 1'b1;
      WAIT_LOCK,
      STABILIZE: ;
      CPU_RUN:   reset_cpu_d = 1'b0;
      RUN: begin
        reset_cpu_d = 1'b0;
        reset_usb_d = 1'b0;
        ready_d     = 1'b1;
      end
      default:   pll_areset_d = 1'b1;
    endcase
  end

  assign pll_areset    = pll_areset_q;
  assign reset_cpu     = reset_cpu_q;
  assign reset_usb     = reset_usb_q;
  assign ready         = ready_q;
  assign lock_lost_cnt = lost_q;

endmodule
